// File: rtl/serializer_pkg.sv
// Shared types and helpers for the operand serializer: FSM state enum and counter width.
package serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Bit counter width: $clog2(width), never below one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/operand_shift_reg.sv
// Loadable operand shift register with a serial bit output.
// SERIALIZER_LSB_FIRST_EN: shift right and emit bit 0 first; otherwise MSB first.
module operand_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             serial_out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Load wins over shift; both are qualified by the owning FSM.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end else if (shift) begin
`ifdef SERIALIZER_LSB_FIRST_EN
            data_d = data_q >> 1;
`else
            data_d = data_q << 1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

`ifdef SERIALIZER_LSB_FIRST_EN
    assign serial_out = data_q[0];
`else
    assign serial_out = data_q[WIDTH-1];
`endif

endmodule

// File: rtl/serial_operand_serializer.sv
// Streams a WIDTH-bit operand pair one bit per cycle with first/last word markers.
// Bit order selected by SERIALIZER_LSB_FIRST_EN (undefined: MSB first).
module serial_operand_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    output logic             out_a,
    output logic             out_b,
    output logic             out_first,
    output logic             out_last
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             load_c;
    logic             shift_c;
    logic             xfer_c;
    logic             cnt_zero_c;
    logic             bit_a_c;
    logic             bit_b_c;

    assign cnt_zero_c = (cnt_q == '0);
    assign in_ready   = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_SHIFT) & cnt_zero_c));
    assign xfer_c     = in_valid & in_ready;

    // Next state: load on transfer, shift through the word, reload or idle at the last bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_c  = 1'b0;
        shift_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer_c) begin
                    load_c  = 1'b1;
                    cnt_d   = CNT_TOP;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_zero_c) begin
                    if (xfer_c) begin
                        load_c = 1'b1;
                        cnt_d  = CNT_TOP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    shift_c = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    operand_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shift_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_c),
        .shift     (shift_c),
        .load_data (in_a),
        .serial_out(bit_a_c)
    );

    operand_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shift_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_c),
        .shift     (shift_c),
        .load_data (in_b),
        .serial_out(bit_b_c)
    );

    // All serial outputs are gated so they read 0 outside a word.
    assign out_valid = (state_q == ST_SHIFT);
    assign out_a     = out_valid & bit_a_c;
    assign out_b     = out_valid & bit_b_c;
    assign out_first = out_valid & (cnt_q == CNT_TOP);
    assign out_last  = out_valid & cnt_zero_c;

endmodule

// File: doc/serial_operand_serializer.md
# serial_operand_serializer

Parallel-to-serial front end for the serial comparators. It accepts a pair of WIDTH-bit operands through a valid/ready handshake and streams them out one bit per cycle, most significant bit first. It marks the first and last bit of each word so a downstream serial comparator can restart per word and sample its result on the last bit. Back-to-back words stream with no bubble cycle.

## Interface
- WIDTH, 8, operand width in bits; legal range ≥ 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  operand pair on in_a/in_b is valid.
- in_ready  out  1  block accepts the operand pair this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- out_valid  out  1  out_a/out_b carry a valid bit this cycle.
- out_a  out  1  current bit of A.
- out_b  out  1  current bit of B.
- out_first  out  1  current bit is bit WIDTH-1, the first bit of the word.
- out_last  out  1  current bit is bit 0, the last bit of the word.

## Operation
- FSM states, held in a two-value enum:
  - ST_IDLE: no word in flight.
  - ST_SHIFT: a word is being streamed.
- Handshake: a transfer occurs on a rising edge where in_valid & in_ready are both 1.
- in_ready is combinational: (state == ST_IDLE) | (state == ST_SHIFT & out_last). It is forced to 0 while rst_n is 0.
- ST_IDLE:
  - On a transfer, load both shift registers from in_a/in_b, set bit counter = WIDTH-1, go to ST_SHIFT.
  - Otherwise stay in ST_IDLE.
- ST_SHIFT:
  - Each cycle, shift both registers left by one and decrement the counter.
  - out_a/out_b = the MSB of each register.
  - out_first = (counter == WIDTH-1); out_last = (counter == 0).
- Last bit (counter == 0):
  - With a transfer: reload from the inputs and stay in ST_SHIFT. The next word's first bit follows immediately.
  - Without a transfer: go to ST_IDLE.
- WIDTH == 1: out_first and out_last are both 1 on the single bit.
- Counter width is $clog2(WIDTH), with a minimum of 1 bit. The counter never wraps: it is reloaded or the FSM leaves ST_SHIFT at 0.
- in_a/in_b are sampled only on a transfer edge. Changes at any other time have no effect.
- out_a, out_b, out_first and out_last are 0 whenever out_valid is 0.

## Timing
- Reset values: state ST_IDLE, out_valid 0, out_a 0, out_b 0, out_first 0, out_last 0, in_ready 0.
- Transfer at edge k gives out_valid = 1 from edge k to edge k+WIDTH, carrying bits WIDTH-1 … 0. out_first is high in the first cycle, out_last in the final one.
- Latency from transfer to first output bit: one edge.
- Throughput: one word per WIDTH cycles with continuous in_valid.
- Reset in the middle of a word:
  - The word is abandoned.
  - All outputs read 0 in the cycle after the reset edge.
  - No partial resume after rst_n returns to 1.
- in_valid during ST_SHIFT with out_last = 0: in_ready is 0. The upstream source holds its data; nothing is lost.

## Configuration
- SERIALIZER_LSB_FIRST_EN:
  - Defined: registers shift right; bit 0 is emitted first. out_first marks bit 0 and out_last marks bit WIDTH-1. This feeds the least-significant-first comparator.
  - Undefined (default): MSB-first ordering as described above.
- The handshake, counter, timing and reset behaviour are identical in both builds.

## Structure
- serializer_pkg holds:
  - the state enum typedef (ST_IDLE, ST_SHIFT);
  - a localparam function computing the counter width from WIDTH.
- Sub-module operand_shift_reg:
  - Parameterised WIDTH, with load and shift inputs and a serial bit output.
  - Obeys SERIALIZER_LSB_FIRST_EN.
  - Instantiated twice, once for A and once for B.
- The FSM, counter and flag logic stay in the top module.

## Test plan
- Reset check: hold rst_n = 0 for 2 cycles → in_ready = 0, out_valid = 0, and all serial outputs 0.
- Single word, WIDTH = 8: in_a = 8'h64, in_b = 8'h62 → out_a = 0,1,1,0,0,1,0,0 and out_b = 0,1,1,0,0,0,1,0 over 8 cycles. out_first is high in cycle 1 only, out_last in cycle 8 only. Then out_valid drops to 0.
- Back-to-back words: 8'hFF/8'h00, then 8'h81/8'h81, with in_valid held high → 16 consecutive out_valid cycles with no gap. in_ready is high only on the two accepting cycles.
- Backpressure: assert in_valid with new data in cycle 3 of a word → in_ready = 0 until out_last. The new word is accepted on the out_last edge, and the held data is emitted unchanged.
- Reset mid-word: drop rst_n during bit 4 of 8'hA5 → outputs read 0 the next cycle. After release, a new word 8'h3C streams from its first bit.
- WIDTH = 1 build plus SERIALIZER_LSB_FIRST_EN build:
  - WIDTH = 1: out_first = out_last = 1 on the single bit.
  - LSB-first: 8'h64 emits 0,0,1,0,0,1,1,0.
